// File: rtl/parity_pkg.sv
// Shared types and constants for the parity frame shifter.
// State encodings, widths and the parity helper live here.
package parity_pkg;

  localparam int DATA_W  = 7;
  localparam int FRAME_W = 8;
  localparam int CNT_W   = 8;
  localparam int IDX_W   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Even mode: p = XOR(data); odd mode inverts it.
  function automatic logic calc_parity(
    input logic [DATA_W-1:0] data,
    input logic              odd
  );
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/parity_gen.sv
// Combinational frame builder: {data, parity bit}.
// Ports: data_i (7b payload), odd_i (mode), frame_o (8b frame).
module parity_gen
  import parity_pkg::*;
(
  input  logic [DATA_W-1:0]  data_i,
  input  logic               odd_i,
  output logic [FRAME_W-1:0] frame_o
);

  assign frame_o = {data_i, calc_parity(data_i, odd_i)};

endmodule

// File: rtl/parity_frame_shifter.sv
// Accepts a 7-bit word, appends parity, shifts the frame MSB first.
// Ports: clk/rst, in_* upstream handshake, ser_* serial side,
// frame_done pulse and wrapping frame_cnt.
module parity_frame_shifter
  import parity_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_odd,
  output logic              in_ready,
  input  logic              ser_ready,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              frame_done,
  output logic [CNT_W-1:0]  frame_cnt
);

  state_e               state_q, state_d;
  logic [FRAME_W-1:0]   sreg_q, sreg_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [FRAME_W-1:0]   frame;

  parity_gen u_gen (
    .data_i  (in_data),
    .odd_i   (in_odd),
    .frame_o (frame)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        // rst overrides in the register, so in_ready
        // reduces to the IDLE test here.
        if (in_valid) begin
          sreg_d  = frame;
          idx_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (ser_ready) begin
          sreg_d = {sreg_q[FRAME_W-2:0], 1'b0};
          idx_d  = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        cnt_d   = cnt_q + 8'd1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready   = (state_q == IDLE) && !rst;
  assign ser_valid  = (state_q == SHIFT);
  assign ser_out    = ser_valid & sreg_q[FRAME_W-1];
  assign frame_done = (state_q == DONE);
  assign frame_cnt  = cnt_q;

endmodule

// File: tb/tb_parity_frame_shifter.sv
// Self-checking bench for parity_frame_shifter.
// Vector table plus serial-bit scoreboard queue.
module tb_parity_frame_shifter;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [6:0] in_data;
  logic       in_odd;
  logic       in_ready;
  logic       ser_ready;
  logic       ser_out;
  logic       ser_valid;
  logic       frame_done;
  logic [7:0] frame_cnt;

  parity_frame_shifter dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_odd     (in_odd),
    .in_ready   (in_ready),
    .ser_ready  (ser_ready),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  logic exp_q[$];
  logic [7:0] cnt_exp;

  typedef struct {
    logic [6:0] d;
    logic       odd;
    int         stall_at;
    int         stall_len;
    logic [7:0] frm;
  } vec_t;

  vec_t tv[7];

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic logic [7:0] model(input logic [6:0] d, input logic odd);
    int ones = 0;
    for (int i = 0; i < 7; i++) ones += d[i];
    // Parity bit makes the total ones-count even (or odd).
    return {d, ((ones % 2) == 1) ^ odd};
  endfunction

  // Sends one frame and checks every serial bit from the queue.
  // abort_at >= 0 applies rst for rst_len cycles at that bit.
  task automatic run_frame(
    input logic [6:0] d,
    input logic       odd,
    input logic [7:0] frm,
    input int         stall_at,
    input int         stall_len,
    input bit         intrude,
    input int         abort_at,
    input int         rst_len
  );
    int cyc;
    for (int b = 7; b >= 0; b--) exp_q.push_back(frm[b]);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    in_valid  = 1'b1;
    in_data   = d;
    in_odd    = odd;
    ser_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 7'($urandom);
    in_odd   = 1'($urandom);
    cyc = 1;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b0;
      if (k == abort_at) begin
        rst = 1'b1;
        repeat (rst_len) begin
          @(negedge clk);
          check("rst_in_ready", in_ready, 0);
          check("rst_ser_valid", ser_valid, 0);
          check("rst_ser_out", ser_out, 0);
          check("rst_frame_done", frame_done, 0);
          check("rst_frame_cnt", frame_cnt, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_done", frame_done, 0);
        check("post_rst_cnt", frame_cnt, 0);
        cnt_exp = 8'd0;
        exp_q.delete();
        return;
      end
      if (intrude && k == 3) begin
        in_valid = 1'b1;
        in_data  = 7'h7F;
        in_odd   = 1'b1;
        check("intrude_in_ready", in_ready, 0);
      end
      if (k == stall_at) begin
        ser_ready = 1'b0;
        repeat (stall_len) begin
          check("stall_valid", ser_valid, 1);
          check("stall_hold", ser_out, exp_q[0]);
          @(negedge clk);
          in_valid = 1'b0;
          cyc++;
        end
        ser_ready = 1'b1;
      end
      check("bit_valid", ser_valid, 1);
      check($sformatf("bit%0d", k), ser_out, exp_q.pop_front());
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    check("done_pulse", frame_done, 1);
    check("done_ser_valid", ser_valid, 0);
    check("done_ser_out", ser_out, 0);
    check("done_latency", cyc, 9 + stall_len);
    cnt_exp = cnt_exp + 8'd1;
    @(negedge clk);
    check("done_cleared", frame_done, 0);
    check("back_idle", in_ready, 1);
    check("frame_cnt", frame_cnt, cnt_exp);
  endtask

  initial begin
    tv[0] = '{7'b1010011, 1'b0, -1, 0, 8'b10100110};
    tv[1] = '{7'b1010011, 1'b1, -1, 0, 8'b10100111};
    tv[2] = '{7'b1010011, 1'b0,  2, 3, 8'b10100110};
    tv[3] = '{7'h00,      1'b0, -1, 0, 8'h00};
    tv[4] = '{7'h00,      1'b1, -1, 0, 8'h01};
    tv[5] = '{7'h7F,      1'b0,  7, 1, 8'hFF};
    tv[6] = '{7'h7F,      1'b1,  0, 2, 8'hFE};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_odd    = 1'b0;
    ser_ready = 1'b1;
    cnt_exp   = 8'd0;
    repeat (2) begin
      @(negedge clk);
      check("init_rst_ready", in_ready, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("init_ready", in_ready, 1);
    check("init_ser_valid", ser_valid, 0);
    check("init_cnt", frame_cnt, 0);
    check("init_done", frame_done, 0);

    for (int i = 0; i < 7; i++) begin
      run_frame(tv[i].d, tv[i].odd, tv[i].frm,
                tv[i].stall_at, tv[i].stall_len, 1'b0, -1, 0);
    end

    // Two-cycle reset from mid-frame with a nonzero count.
    run_frame(7'h35, 1'b0, model(7'h35, 1'b0), -1, 0, 1'b0, 5, 2);

    // Intrusion at bit 3, then abort at bit 4.
    run_frame(7'b1010011, 1'b0, 8'b10100110, -1, 0, 1'b1, 4, 1);

    // Intrusion alone must not disturb the frame in flight.
    run_frame(7'b1010011, 1'b1, 8'b10100111, -1, 0, 1'b1, -1, 0);

    // Counter wrap: bring count back to 0 then run 256 frames.
    run_frame(7'h11, 1'b0, model(7'h11, 1'b0), -1, 0, 1'b0, 1, 1);
    for (int i = 0; i < 256; i++) begin
      logic [6:0] d;
      logic       o;
      d = 7'($urandom);
      o = 1'($urandom);
      if (i == 255) check("pre_wrap_cnt", frame_cnt, 255);
      run_frame(d, o, model(d, o), -1, 0, 1'b0, -1, 0);
    end
    check("wrap_cnt", frame_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
